// File: rtl/patch_embed_pingpong.sv
// Patch-embed combine stage with ping-pong result RAM banks.
// One bank fills with a frame while the other is drained by the array.
module patch_embed_pingpong #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 4096
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic [1:0]            i_mode,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic [DATA_W-1:0]     i_fmap,
  input  logic [DATA_W-1:0]     i_patchdata,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  input  logic                  i_rd_release,
  output logic [2*DATA_W-1:0]   o_ramout_data,
  output logic                  o_ramout_valid,
  output logic                  o_bank_ready,
  output logic                  o_rd_bank,
  output logic                  o_frame_done,
  output logic                  o_overflow
);

  localparam int WORD_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              w_vld_q, w_vld_d;
  logic              w_last_q, w_last_d;
  logic              w_bank_q, w_bank_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [WORD_W-1:0] w_data_q, w_data_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              r_vld_q, r_vld_d;
  logic              r_bank_q, r_bank_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              m_vld_q, m_vld_d;
  logic              o_vld_q, o_vld_d;
  logic [WORD_W-1:0] o_data_q, o_data_d;
  logic [WORD_W-1:0] ram_rd_q;

  logic [WORD_W-1:0] mem0_q [DEPTH];
  logic [WORD_W-1:0] mem1_q [DEPTH];

  logic              ready;
  logic              accept;
  logic              release_ok;
  logic              issue;
  logic [1:0]        eff_mode;
  logic [WORD_W-1:0] word;

  assign ready          = !s_rst && !full_q[wr_bank_q];
  assign o_data_ready   = ready;
  assign o_bank_ready   = full_q[rd_bank_q];
  assign o_rd_bank      = rd_bank_q;
  assign o_frame_done   = done_q;
  assign o_overflow     = ovf_q;
  assign o_ramout_valid = o_vld_q;
  assign o_ramout_data  = o_data_q;

  always_comb begin
    accept     = i_data_valid && ready;
    release_ok = i_rd_release && full_q[rd_bank_q];
    issue      = i_rd_en && full_q[rd_bank_q];
    // first beat of a frame picks the live mode, the rest reuse it
    eff_mode   = (wr_cnt_q == '0) ? i_mode : mode_q;
    word       = '0;
    for (int k = 0; k < DATA_W; k++) begin
      case (eff_mode)
        2'b01:   word[2*k +: 2] = {1'b0, i_fmap[k] | i_patchdata[k]};
        2'b10:   word[2*k +: 2] = {1'b0, i_fmap[k]};
        default: word[2*k +: 2] = {i_fmap[k] & i_patchdata[k],
                                   i_fmap[k] ^ i_patchdata[k]};
      endcase
    end

    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    mode_d    = mode_q;
    w_vld_d   = accept;
    w_last_d  = (wr_cnt_q == LAST);
    w_bank_d  = wr_bank_q;
    w_addr_d  = wr_cnt_q;
    w_data_d  = word;
    if (accept) begin
      mode_d = eff_mode;
      if (wr_cnt_q == LAST) begin
        wr_cnt_d  = '0;
        wr_bank_d = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    ovf_d = ovf_q || (i_data_valid && !ready);

    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    if (release_ok) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    if (w_vld_q && w_last_q) full_d[w_bank_q] = 1'b1;
    done_d = w_vld_q && w_last_q;

    r_vld_d  = issue;
    r_bank_d = rd_bank_q;
    r_addr_d = i_rd_addr;
    m_vld_d  = r_vld_q;
    o_vld_d  = m_vld_q;
    o_data_d = m_vld_q ? ram_rd_q : o_data_q;
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      wr_cnt_q  <= '0;
      mode_q    <= '0;
      w_vld_q   <= 1'b0;
      w_last_q  <= 1'b0;
      w_bank_q  <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      r_vld_q   <= 1'b0;
      r_bank_q  <= 1'b0;
      r_addr_q  <= '0;
      m_vld_q   <= 1'b0;
      o_vld_q   <= 1'b0;
      o_data_q  <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      wr_cnt_q  <= wr_cnt_d;
      mode_q    <= mode_d;
      w_vld_q   <= w_vld_d;
      w_last_q  <= w_last_d;
      w_bank_q  <= w_bank_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      r_vld_q   <= r_vld_d;
      r_bank_q  <= r_bank_d;
      r_addr_q  <= r_addr_d;
      m_vld_q   <= m_vld_d;
      o_vld_q   <= o_vld_d;
      o_data_q  <= o_data_d;
    end
  end

  // embedded RAM: no reset on the arrays or the raw read register
  always_ff @(posedge s_clk) begin
    if (w_vld_q) begin
      if (w_bank_q) mem1_q[w_addr_q] <= w_data_q;
      else          mem0_q[w_addr_q] <= w_data_q;
    end
    ram_rd_q <= r_bank_q ? mem1_q[r_addr_q] : mem0_q[r_addr_q];
  end

endmodule

// File: tb/tb_patch_embed_pingpong.sv
// Directed bench for patch_embed_pingpong.
// Small geometry: 4 lanes, 4-word banks, 4-beat frames.
module tb_patch_embed_pingpong;

  localparam int DW = 4;
  localparam int DP = 4;
  localparam int AW = 2;
  localparam int FL = 4;

  logic          s_clk = 1'b0;
  logic          s_rst;
  logic [1:0]    i_mode;
  logic          i_data_valid;
  logic          o_data_ready;
  logic [DW-1:0] i_fmap;
  logic [DW-1:0] i_patchdata;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic          i_rd_release;
  logic [2*DW-1:0] o_ramout_data;
  logic          o_ramout_valid;
  logic          o_bank_ready;
  logic          o_rd_bank;
  logic          o_frame_done;
  logic          o_overflow;

  int nvec = 0;
  int nerr = 0;

  always #5 s_clk = ~s_clk;

  patch_embed_pingpong #(
    .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .FRAME_LEN(FL)
  ) dut (
    .s_clk(s_clk),
    .s_rst(s_rst),
    .i_mode(i_mode),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .i_fmap(i_fmap),
    .i_patchdata(i_patchdata),
    .i_rd_en(i_rd_en),
    .i_rd_addr(i_rd_addr),
    .i_rd_release(i_rd_release),
    .o_ramout_data(o_ramout_data),
    .o_ramout_valid(o_ramout_valid),
    .o_bank_ready(o_bank_ready),
    .o_rd_bank(o_rd_bank),
    .o_frame_done(o_frame_done),
    .o_overflow(o_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [3:0] f,
                      input logic [3:0] p);
    i_mode       = m;
    i_fmap       = f;
    i_patchdata  = p;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
  endtask

  task automatic frame(input logic [1:0] m, input logic [3:0] f,
                       input logic [3:0] p);
    repeat (FL) beat(m, f, p);
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    tick();
    tick();
    s_rst = 1'b0;
    tick();
  endtask

  task automatic rd1(input logic [AW-1:0] a, input logic [7:0] exp,
                     input string tag);
    i_rd_en   = 1'b1;
    i_rd_addr = a;
    tick();
    i_rd_en = 1'b0;
    tick();
    chk({tag, "_lat"}, o_ramout_valid, 1'b0);
    tick();
    chk({tag, "_vld"}, o_ramout_valid, 1'b1);
    chk({tag, "_dat"}, o_ramout_data, exp);
  endtask

  task automatic rd4(input logic [7:0] exp, input string tag);
    for (int i = 0; i < FL + 2; i++) begin
      i_rd_en   = (i < FL);
      i_rd_addr = AW'(i);
      tick();
      if (i == 1) chk({tag, "_lat"}, o_ramout_valid, 1'b0);
      if (i >= 2) begin
        chk($sformatf("%s_vld%0d", tag, i - 2), o_ramout_valid, 1'b1);
        chk($sformatf("%s_dat%0d", tag, i - 2), o_ramout_data, exp);
      end
    end
    i_rd_en = 1'b0;
    tick();
    chk({tag, "_end"}, o_ramout_valid, 1'b0);
  endtask

  task automatic release_bank();
    i_rd_release = 1'b1;
    tick();
    i_rd_release = 1'b0;
  endtask

  initial begin
    s_rst        = 1'b1;
    i_mode       = 2'b00;
    i_data_valid = 1'b0;
    i_fmap       = '0;
    i_patchdata  = '0;
    i_rd_en      = 1'b0;
    i_rd_addr    = '0;
    i_rd_release = 1'b0;

    // reset state
    tick();
    chk("rst_ready", o_data_ready, 1'b0);
    chk("rst_bank_ready", o_bank_ready, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_vld", o_ramout_valid, 1'b0);
    s_rst = 1'b0;
    tick();
    chk("post_rst_ready", o_data_ready, 1'b1);

    // add frame into bank 0
    frame(2'b00, 4'b1011, 4'b0110);
    chk("t1_done_early", o_frame_done, 1'b0);
    tick();
    chk("t1_done", o_frame_done, 1'b1);
    chk("t1_bank_ready", o_bank_ready, 1'b1);
    chk("t1_rd_bank", o_rd_bank, 1'b0);
    tick();
    chk("t1_done_pulse", o_frame_done, 1'b0);
    rd4(8'h59, "t1_rd");

    // or frame into bank 0, pass frame into bank 1
    do_reset();
    frame(2'b01, 4'b1011, 4'b0110);
    frame(2'b10, 4'b1011, 4'b0110);
    tick();
    chk("t2_ready_full", o_data_ready, 1'b0);
    rd1(2'd0, 8'h55, "t2_b0");
    release_bank();
    chk("t2_rd_bank", o_rd_bank, 1'b1);
    chk("t2_bank_ready", o_bank_ready, 1'b1);
    chk("t2_ready", o_data_ready, 1'b1);
    rd1(2'd2, 8'h45, "t2_b1");

    // mode change after the first beat is ignored
    do_reset();
    beat(2'b00, 4'b1011, 4'b0110);
    repeat (FL - 1) beat(2'b10, 4'b1011, 4'b0110);
    tick();
    rd4(8'h59, "t3_rd");

    // both banks full, dropped beats set sticky overflow
    do_reset();
    frame(2'b00, 4'b1011, 4'b0110);
    frame(2'b01, 4'b1011, 4'b0110);
    tick();
    chk("t4_ready", o_data_ready, 1'b0);
    chk("t4_ovf0", o_overflow, 1'b0);
    beat(2'b10, 4'b0000, 4'b0000);
    chk("t4_ovf1", o_overflow, 1'b1);
    beat(2'b10, 4'b0000, 4'b0000);
    beat(2'b10, 4'b0000, 4'b0000);
    tick();
    chk("t4_ovf_hold", o_overflow, 1'b1);
    chk("t4_ready2", o_data_ready, 1'b0);
    rd1(2'd0, 8'h59, "t4_b0a");
    rd1(2'd3, 8'h59, "t4_b0b");
    release_bank();
    chk("t4_ready_rel", o_data_ready, 1'b1);
    chk("t4_ovf_rel", o_overflow, 1'b1);

    // read issued with release returns old-bank data; mode 11 adds
    do_reset();
    frame(2'b11, 4'b1011, 4'b0110);
    frame(2'b01, 4'b1011, 4'b0110);
    tick();
    i_rd_en      = 1'b1;
    i_rd_addr    = 2'd1;
    i_rd_release = 1'b1;
    tick();
    i_rd_release = 1'b0;
    i_rd_addr    = 2'd2;
    tick();
    chk("t5_rd_bank", o_rd_bank, 1'b1);
    i_rd_en = 1'b0;
    tick();
    chk("t5_old_vld", o_ramout_valid, 1'b1);
    chk("t5_old_dat", o_ramout_data, 8'h59);
    tick();
    chk("t5_new_vld", o_ramout_valid, 1'b1);
    chk("t5_new_dat", o_ramout_data, 8'h55);
    tick();
    chk("t5_idle_vld", o_ramout_valid, 1'b0);
    chk("t5_hold_dat", o_ramout_data, 8'h55);

    // reset mid-frame
    beat(2'b00, 4'b1011, 4'b0110);
    beat(2'b00, 4'b1011, 4'b0110);
    s_rst = 1'b1;
    tick();
    chk("t6_ready", o_data_ready, 1'b0);
    chk("t6_bank_ready", o_bank_ready, 1'b0);
    chk("t6_rd_bank", o_rd_bank, 1'b0);
    chk("t6_done", o_frame_done, 1'b0);
    chk("t6_ovf", o_overflow, 1'b0);
    chk("t6_vld", o_ramout_valid, 1'b0);
    chk("t6_dat", o_ramout_data, 8'h00);
    s_rst = 1'b0;
    tick();
    chk("t6_ready_after", o_data_ready, 1'b1);
    chk("t6_bank_ready_after", o_bank_ready, 1'b0);
    frame(2'b10, 4'b1011, 4'b0110);
    tick();
    chk("t6_full", o_bank_ready, 1'b1);
    chk("t6_full_bank", o_rd_bank, 1'b0);
    rd4(8'h45, "t6_rd");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
